stimulus_sequencer: RTL

Sits directly upstream of the system reset manager and the DUT stimulus inputs. Accepts stimulus records on an AXI-Stream slave, buffers them in a small FIFO, and replays each record as a timed `stimuli_valid` pulse with accompanying `stimuli_data` and `do_reset`. It enforces a guaranteed low gap between pulses so every record produces a clean rising edge downstream. For records with `do_reset` set, it stalls until the reset manager's `resetn` has gone low and come back high.

---
 rtl/stim_pkg.sv | 24 ++
 rtl/stimulus_sequencer_if.sv | 16 +
 rtl/stim_fifo.sv | 55 +++++
 rtl/stimulus_sequencer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/stim_pkg.sv
// Shared types and default parameters for the stimulus sequencer.
package stim_pkg;

  localparam int unsigned DEF_DATA_W      = 32;
  localparam int unsigned DEF_HOLD_W      = 8;
  localparam int unsigned DEF_GAP_CYCLES  = 2;
  localparam int unsigned DEF_FIFO_DEPTH  = 16;
  localparam int unsigned DEF_RST_TIMEOUT = 64;

  typedef struct packed {
    logic                  do_reset;
    logic [DEF_HOLD_W-1:0] hold;
    logic [DEF_DATA_W-1:0] data;
  } stim_rec_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PULSE,
    ST_GAP,
    ST_WAIT_LO,
    ST_WAIT_HI
  } stim_state_t;

endpackage

// File: rtl/stimulus_sequencer_if.sv
// AXI-Stream record channel feeding the stimulus sequencer.
interface stimulus_sequencer_if
  import stim_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned HOLD_W = DEF_HOLD_W
);

  logic [DATA_W+HOLD_W:0] tdata;
  logic                   tvalid;
  logic                   tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/stim_fifo.sv
// Single-clock record FIFO; registered flags, no fall-through on empty.
module stim_fifo
  import stim_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_DATA_W + DEF_HOLD_W + 1,
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full & ~reset;
  assign do_pop  = pop & ~empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/stimulus_sequencer.sv
// Replays buffered stimulus records as timed pulses, with optional reset-manager handshake.
module stimulus_sequencer
  import stim_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned HOLD_W      = DEF_HOLD_W,
  parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int unsigned RST_TIMEOUT = DEF_RST_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  stimulus_sequencer_if.slave s_axis,
  input  logic                resetn,
  output logic                stimuli_valid,
  output logic [DATA_W-1:0]   stimuli_data,
  output logic                do_reset,
  output logic                busy,
  output logic                rst_timeout
);

  localparam int unsigned REC_W = DATA_W + HOLD_W + 1;
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int unsigned TMO_W = $clog2(RST_TIMEOUT + 1);

  stim_state_t       state, state_nx;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic [REC_W-1:0]  rec;
  logic [DATA_W-1:0] rec_data;
  logic [HOLD_W-1:0] rec_hold;
  logic              rec_rst;

  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nx;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_nx;
  logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_nx;
  logic              lo_seen, lo_seen_nx;
  logic              valid_nx, rst_nx, tmo_flag_nx;
  logic [DATA_W-1:0] data_nx;
  logic              tmo_hit;

  stim_fifo #(.WIDTH(REC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (s_axis.tvalid),
    .wdata (s_axis.tdata),
    .pop   (fifo_pop),
    .rdata (rec),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign s_axis.tready = ~fifo_full;
  assign busy          = ~fifo_empty | (state != ST_IDLE);
  assign rec_data      = rec[DATA_W-1:0];
  assign rec_hold      = rec[DATA_W +: HOLD_W];
  assign rec_rst       = rec[REC_W-1];
  assign tmo_hit       = (tmo_cnt == TMO_W'(RST_TIMEOUT - 1));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      stimuli_valid <= 1'b0;
      stimuli_data  <= '0;
      do_reset      <= 1'b0;
      rst_timeout   <= 1'b0;
      hold_cnt      <= '0;
      gap_cnt       <= '0;
      tmo_cnt       <= '0;
      lo_seen       <= 1'b0;
    end else begin
      state         <= state_nx;
      stimuli_valid <= valid_nx;
      stimuli_data  <= data_nx;
      do_reset      <= rst_nx;
      rst_timeout   <= tmo_flag_nx;
      hold_cnt      <= hold_cnt_nx;
      gap_cnt       <= gap_cnt_nx;
      tmo_cnt       <= tmo_cnt_nx;
      lo_seen       <= lo_seen_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (!fifo_empty) state_nx = ST_PULSE;
      ST_PULSE:   if (hold_cnt == HOLD_W'(1)) state_nx = do_reset ? ST_WAIT_LO : ST_GAP;
      ST_WAIT_LO: if (lo_seen || !resetn) state_nx = ST_WAIT_HI;
                  else if (tmo_hit)       state_nx = ST_GAP;
      ST_WAIT_HI: if (resetn || tmo_hit)  state_nx = ST_GAP;
      ST_GAP:     if (gap_cnt == GAP_W'(1)) state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // Next values for outputs and counters
  always_comb begin
    fifo_pop    = 1'b0;
    valid_nx    = stimuli_valid;
    data_nx     = stimuli_data;
    rst_nx      = do_reset;
    tmo_flag_nx = rst_timeout;
    hold_cnt_nx = hold_cnt;
    gap_cnt_nx  = gap_cnt;
    tmo_cnt_nx  = tmo_cnt;
    lo_seen_nx  = lo_seen;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          valid_nx    = 1'b1;
          data_nx     = rec_data;
          rst_nx      = rec_rst;
          hold_cnt_nx = (rec_hold == '0) ? HOLD_W'(1) : rec_hold;
          lo_seen_nx  = 1'b0;
        end
      end
      ST_PULSE: begin
        hold_cnt_nx = hold_cnt - HOLD_W'(1);
        // A reset-manager low that arrives early still satisfies the wait
        if (!resetn) lo_seen_nx = 1'b1;
        if (hold_cnt == HOLD_W'(1)) begin
          valid_nx   = 1'b0;
          data_nx    = '0;
          rst_nx     = 1'b0;
          tmo_cnt_nx = '0;
          gap_cnt_nx = GAP_W'(GAP_CYCLES);
        end
      end
      ST_WAIT_LO: begin
        if (lo_seen || !resetn) begin
          tmo_cnt_nx = '0;
        end else if (tmo_hit) begin
          tmo_flag_nx = 1'b1;
          gap_cnt_nx  = GAP_W'(GAP_CYCLES);
        end else begin
          tmo_cnt_nx = tmo_cnt + TMO_W'(1);
        end
      end
      ST_WAIT_HI: begin
        if (resetn) begin
          gap_cnt_nx = GAP_W'(GAP_CYCLES);
        end else if (tmo_hit) begin
          tmo_flag_nx = 1'b1;
          gap_cnt_nx  = GAP_W'(GAP_CYCLES);
        end else begin
          tmo_cnt_nx = tmo_cnt + TMO_W'(1);
        end
      end
      ST_GAP:  gap_cnt_nx = gap_cnt - GAP_W'(1);
      default: ;
    endcase
  end

endmodule
